// File: rtl/ultrasound_pkg.sv
// Shared state encodings and arithmetic helpers for the ultrasound array ranger.
package ultrasound_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_TRIGGER   = 4'd1,
    ST_WAIT_RISE = 4'd2,
    ST_MEASURE   = 4'd3,
    ST_POWER_OFF = 4'd4,
    ST_GAP       = 4'd5,
    ST_MEDIAN    = 4'd6,
    ST_REPORT    = 4'd7
  } state_e;

  localparam int unsigned MAX_DIST_W = 16;

  typedef logic [MAX_DIST_W-1:0] dist_t;

  typedef struct packed {
    logic  vld;
    dist_t val;
  } med_t;

  // Invalid samples sort as all-ones; two or more invalid samples void the result.
  function automatic med_t median3(input dist_t a, input dist_t b, input dist_t c,
                                   input logic [2:0] inv, input dist_t ones);
    dist_t x, y, z, lo, hi;
    med_t  r;
    x = inv[0] ? ones : a;
    y = inv[1] ? ones : b;
    z = inv[2] ? ones : c;
    lo = (x < y) ? x : y;
    hi = (x < y) ? y : x;
    r.val = (z < lo) ? lo : ((z > hi) ? hi : z);
    r.vld = ($countones(inv) < 2);
    return r;
  endfunction

  function automatic dist_t sat_add(input dist_t a, input dist_t b, input dist_t max);
    logic [MAX_DIST_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[MAX_DIST_W-1:0];
  endfunction

endpackage

// File: rtl/ultrasound_echo_timer.sv
// Echo pulse timer shared by all channels: rise/fall detection, cycle counter,
// timeout flag and scaled sample. Strobes are combinational from the counter state.
module ultrasound_echo_timer #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DIST_W    = 8,
  parameter int unsigned DIV_SHIFT = 1,
  parameter int unsigned TIMEOUT   = 100
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wait_i,
  input  logic              meas_i,
  input  logic              echo_i,
  output logic              rise_o,
  output logic              fall_o,
  output logic              timeout_o,
  output logic [DIST_W-1:0] sample_o
);

  localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] DIST_MAX = CNT_W'((64'd1 << DIST_W) - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, shifted;

  assign cnt_inc = cnt_q + 1'b1;
  assign shifted = cnt_q >> DIV_SHIFT;
  assign sample_o = (shifted > DIST_MAX) ? {DIST_W{1'b1}} : DIST_W'(shifted);

  // The counter doubles as the wait-for-rise timer and the echo-width counter.
  always_comb begin
    cnt_d     = '0;
    rise_o    = 1'b0;
    fall_o    = 1'b0;
    timeout_o = 1'b0;
    if (wait_i) begin
      if (echo_i) begin
        rise_o = 1'b1;
        cnt_d  = CNT_W'(1);
      end else begin
        cnt_d     = cnt_inc;
        timeout_o = (cnt_inc >= TMO);
      end
    end else if (meas_i) begin
      if (echo_i) begin
        cnt_d     = cnt_inc;
        timeout_o = (cnt_inc >= TMO);
      end else begin
        fall_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ultrasound_array_ranger.sv
// Sweeps enabled ultrasound channels, takes the median of three echo timings each and
// reports the nearest sensor. Optional timeout power-cycling: ULTRASOUND_POWER_CYCLE_EN.
module ultrasound_array_ranger
  import ultrasound_pkg::*;
#(
  parameter int unsigned NUM_SENSORS      = 10,
  parameter int unsigned IDX_W            = 4,
  parameter int unsigned DIST_W           = 8,
  parameter int unsigned CNT_W            = 16,
  parameter int unsigned DIV_SHIFT        = 1,
  parameter int unsigned OFFSET           = 5,
  parameter int unsigned TRIGGER_CYCLES   = 4,
  parameter int unsigned GAP_CYCLES       = 5,
  parameter int unsigned TIMEOUT          = 100,
  parameter int unsigned POWER_OFF_CYCLES = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    calculate,
  input  logic [NUM_SENSORS-1:0]  sensor_mask,
  input  logic [NUM_SENSORS-1:0]  ultrasound_signals,
  output logic [NUM_SENSORS-1:0]  ultrasound_commands,
  output logic [NUM_SENSORS-1:0]  ultrasound_power,
  output logic [IDX_W+DIST_W-1:0] rover_location,
  output logic                    no_target,
  output logic                    done,
  output logic                    busy,
  output logic [3:0]              state
);

  localparam dist_t DIST_ONES = dist_t'((64'd1 << DIST_W) - 1);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cyc_q, cyc_d;
  logic [IDX_W-1:0]          idx_q, idx_d, best_idx_q, best_idx_d;
  logic [NUM_SENSORS-1:0]    pending_q, pending_d, sel;
  logic [1:0]                samp_n_q, samp_n_d;
  logic [2:0][DIST_W-1:0]    samp_q, samp_d;
  logic [2:0]                samp_inv_q, samp_inv_d;
  logic                      best_vld_q, best_vld_d;
  logic [DIST_W-1:0]         best_q, best_d;
  logic [IDX_W+DIST_W-1:0]   loc_q;
  logic                      no_target_q;
  logic                      echo_sel, rise, fall, tmo;
  logic [DIST_W-1:0]         sample;
  med_t                      med;
  dist_t                     med_off;

  function automatic logic [IDX_W-1:0] lowest(input logic [NUM_SENSORS-1:0] m);
    lowest = '0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (m[i]) lowest = IDX_W'(i);
    end
  endfunction

  assign sel      = NUM_SENSORS'(1) << idx_q;
  assign echo_sel = |(ultrasound_signals & sel);

  ultrasound_echo_timer #(
    .CNT_W(CNT_W), .DIST_W(DIST_W), .DIV_SHIFT(DIV_SHIFT), .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .wait_i   (state_q == ST_WAIT_RISE),
    .meas_i   (state_q == ST_MEASURE),
    .echo_i   (echo_sel),
    .rise_o   (rise),
    .fall_o   (fall),
    .timeout_o(tmo),
    .sample_o (sample)
  );

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    idx_d      = idx_q;
    pending_d  = pending_q;
    samp_n_d   = samp_n_q;
    samp_d     = samp_q;
    samp_inv_d = samp_inv_q;
    best_vld_d = best_vld_q;
    best_idx_d = best_idx_q;
    best_d     = best_q;
    med        = median3(dist_t'(samp_q[0]), dist_t'(samp_q[1]), dist_t'(samp_q[2]),
                         samp_inv_q, DIST_ONES);
    med_off    = sat_add(med.val, dist_t'(OFFSET), DIST_ONES);

    case (state_q)
      ST_IDLE: begin
        if (calculate) begin
          pending_d  = sensor_mask;
          idx_d      = lowest(sensor_mask);
          samp_n_d   = '0;
          cyc_d      = '0;
          best_vld_d = 1'b0;
          best_idx_d = '0;
          best_d     = '0;
          state_d    = (sensor_mask == '0) ? ST_REPORT : ST_TRIGGER;
        end
      end
      ST_TRIGGER: begin
        if (cyc_q == CNT_W'(TRIGGER_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = ST_WAIT_RISE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_WAIT_RISE, ST_MEASURE: begin
        if (tmo) begin
          samp_inv_d[samp_n_q] = 1'b1;
`ifdef ULTRASOUND_POWER_CYCLE_EN
          state_d = ST_POWER_OFF;
`else
          state_d = ST_GAP;
`endif
        end else if (rise) begin
          state_d = ST_MEASURE;
        end else if (fall) begin
          samp_d[samp_n_q]     = sample;
          samp_inv_d[samp_n_q] = 1'b0;
          state_d              = ST_GAP;
        end
      end
      ST_POWER_OFF: begin
        if (cyc_q == CNT_W'(POWER_OFF_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = ST_GAP;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cyc_q == CNT_W'(GAP_CYCLES - 1)) begin
          cyc_d = '0;
          if (samp_n_q == 2'd2) begin
            samp_n_d = '0;
            state_d  = ST_MEDIAN;
          end else begin
            samp_n_d = samp_n_q + 1'b1;
            state_d  = ST_TRIGGER;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_MEDIAN: begin
        // Sensors are visited in ascending order, so strict < keeps the lowest index on ties.
        if (med.vld && (!best_vld_q || med_off < dist_t'(best_q))) begin
          best_vld_d = 1'b1;
          best_idx_d = idx_q;
          best_d     = DIST_W'(med_off);
        end
        pending_d = pending_q & ~sel;
        if (pending_d == '0) begin
          state_d = ST_REPORT;
        end else begin
          idx_d   = lowest(pending_d);
          state_d = ST_TRIGGER;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      idx_q       <= '0;
      pending_q   <= '0;
      samp_n_q    <= '0;
      samp_q      <= '0;
      samp_inv_q  <= '0;
      best_vld_q  <= 1'b0;
      best_idx_q  <= '0;
      best_q      <= '0;
      loc_q       <= '0;
      no_target_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      samp_n_q   <= samp_n_d;
      samp_q     <= samp_d;
      samp_inv_q <= samp_inv_d;
      best_vld_q <= best_vld_d;
      best_idx_q <= best_idx_d;
      best_q     <= best_d;
      if (state_d == ST_REPORT && state_q != ST_REPORT) begin
        no_target_q <= !best_vld_d;
        if (best_vld_d) loc_q <= {best_idx_d, best_d};
      end
    end
  end

  assign ultrasound_commands = (state_q == ST_TRIGGER) ? sel : '0;
`ifdef ULTRASOUND_POWER_CYCLE_EN
  assign ultrasound_power = (state_q == ST_POWER_OFF) ? ~sel : '1;
`else
  assign ultrasound_power = '1;
`endif
  assign rover_location = loc_q;
  assign no_target      = no_target_q;
  assign done           = (state_q == ST_REPORT);
  assign busy           = (state_q != ST_IDLE);
  assign state          = state_q;

endmodule

// File: tb/tb_ultrasound_array_ranger.sv
// Self-checking bench: echo responder driven by trigger pulses, results checked
// against a median/minimum reference model computed from per-sensor echo widths.
module tb_ultrasound_array_ranger;
  localparam int NS = 10, TIMEOUT = 100, OFFSET = 5, DIV_SHIFT = 1;
  localparam int TRIG = 4, GAP = 5, PWR = 6;

  logic clock = 1'b0;
  logic reset, calculate;
  logic [NS-1:0] sensor_mask, ultrasound_signals, ultrasound_commands, ultrasound_power;
  logic [11:0] rover_location;
  logic no_target, done, busy;
  logic [3:0] state;

  int total = 0, bad = 0;
  int echo_len[NS][3];
  int trig_cnt[NS];
  bit rand_dly = 0;
  int fixed_dly = 2;
  bit resp_busy = 0;
  logic [11:0] exp_loc = '0;
  logic exp_nt = 1'b0;

  // sweep observations
  bit sw_tmo;
  int sw_cyc, sw_pwr_low;
  logic [3:0] sw_st1;
  logic [NS-1:0] sw_cmd1, sw_pwr_and;
  logic sw_done_after, sw_busy_after, sw_busy_at_done;

  always #5 clock = ~clock;

  ultrasound_array_ranger dut (
    .clock(clock), .reset(reset), .calculate(calculate), .sensor_mask(sensor_mask),
    .ultrasound_signals(ultrasound_signals), .ultrasound_commands(ultrasound_commands),
    .ultrasound_power(ultrasound_power), .rover_location(rover_location),
    .no_target(no_target), .done(done), .busy(busy), .state(state)
  );

  // Echo responder: after a trigger pulse ends, wait, then hold the echo high for the
  // tabled number of cycles on the triggered channel.
  initial begin
    ultrasound_signals = '0;
    forever begin
      @(negedge clock);
      if (ultrasound_commands != '0 && !reset) begin
        int ch, h, d;
        ch = 0;
        for (int i = 0; i < NS; i++) if (ultrasound_commands[i]) ch = i;
        resp_busy = 1;
        for (int n = 0; n < 20 && ultrasound_commands != '0; n++) @(negedge clock);
        h = (trig_cnt[ch] < 3) ? echo_len[ch][trig_cnt[ch]] : 0;
        trig_cnt[ch]++;
        d = rand_dly ? int'($urandom_range(1, 8)) : fixed_dly;
        repeat (d) @(negedge clock);
        if (h > 0) begin
          ultrasound_signals[ch] = 1'b1;
          repeat (h) @(negedge clock);
          ultrasound_signals[ch] = 1'b0;
        end
        resp_busy = 0;
      end
    end
  end

  // Reference: per sensor sample = width>>DIV_SHIFT when 1..TIMEOUT-1 cycles wide,
  // otherwise invalid (sorts as 255); sorted middle value + OFFSET, nearest wins.
  task automatic model(input logic [NS-1:0] m, output bit vld, output logic [11:0] loc);
    int bidx, bdist;
    vld = 0; bidx = 0; bdist = 0;
    for (int s = 0; s < NS; s++) begin
      if (m[s]) begin
        int v[3];
        int ninv, t, dd;
        ninv = 0;
        for (int k = 0; k < 3; k++) begin
          int h;
          h = echo_len[s][k];
          if (h >= 1 && h < TIMEOUT) v[k] = ((h >> DIV_SHIFT) > 255) ? 255 : (h >> DIV_SHIFT);
          else begin v[k] = 255; ninv++; end
        end
        for (int p = 0; p < 2; p++)
          for (int q = 0; q < 2 - p; q++)
            if (v[q] > v[q+1]) begin t = v[q]; v[q] = v[q+1]; v[q+1] = t; end
        if (ninv < 2) begin
          dd = v[1] + OFFSET;
          if (dd > 255) dd = 255;
          if (!vld || dd < bdist) begin vld = 1; bidx = s; bdist = dd; end
        end
      end
    end
    loc = {4'(bidx), 8'(bdist)};
  endtask

  task automatic clear_echo();
    for (int s = 0; s < NS; s++) for (int k = 0; k < 3; k++) echo_len[s][k] = 0;
  endtask

  // Runs one sweep and records observations; all judging happens in the test tasks.
  task automatic do_sweep(input logic [NS-1:0] m, input bit poke);
    for (int i = 0; i < NS; i++) trig_cnt[i] = 0;
    @(negedge clock); sensor_mask = m; calculate = 1'b1;
    @(negedge clock); calculate = 1'b0;
    sw_cyc = 1; sw_st1 = state; sw_cmd1 = ultrasound_commands;
    sw_pwr_low = 0; sw_pwr_and = '1;
    while (!done && sw_cyc < 20000) begin
      if (ultrasound_power != '1) sw_pwr_low++;
      sw_pwr_and &= ultrasound_power;
      calculate = poke && (sw_cyc == 30);
      if (poke && sw_cyc == 30) sensor_mask = ~m;
      @(negedge clock); sw_cyc++;
    end
    calculate = 1'b0;
    sw_tmo = !done; sw_busy_at_done = busy;
    @(negedge clock);
    sw_done_after = done; sw_busy_after = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1; calculate = 1'b0; sensor_mask = '0;
    repeat (3) @(negedge clock);
    total++; if (state !== 4'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
    total++; if (ultrasound_commands !== '0) begin bad++; $display("FAIL rst_cmd got=%h exp=0", ultrasound_commands); end
    total++; if (ultrasound_power !== '1) begin bad++; $display("FAIL rst_power got=%h exp=3ff", ultrasound_power); end
    total++; if (rover_location !== '0) begin bad++; $display("FAIL rst_loc got=%h exp=0", rover_location); end
    total++; if (no_target !== 1'b0) begin bad++; $display("FAIL rst_nt got=%b exp=0", no_target); end
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_done_busy got=%b%b exp=00", done, busy); end
    reset = 1'b0;
    @(negedge clock);
    total++; if (state !== 4'd0) begin bad++; $display("FAIL post_rst_state got=%0d exp=0", state); end
  endtask

  task automatic test_single();
    clear_echo();
    for (int k = 0; k < 3; k++) echo_len[0][k] = 40;
    rand_dly = 0;
    do_sweep(10'h001, 0);
    exp_loc = 12'h019; exp_nt = 0;
    total++; if (sw_st1 !== 4'd1 || sw_cmd1 !== 10'h001) begin bad++; $display("FAIL single_start got=%0d/%h exp=1/001", sw_st1, sw_cmd1); end
    total++; if (sw_tmo) begin bad++; $display("FAIL single_timeout got=no_done exp=done"); end
    // three pings of TRIG + (delay+1) + H + GAP, then MEDIAN and REPORT
    total++; if (sw_cyc != 3 * (TRIG + fixed_dly + 1 + 40 + GAP) + 2) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", sw_cyc, 3 * (TRIG + fixed_dly + 1 + 40 + GAP) + 2); end
    total++; if (rover_location !== exp_loc) begin bad++; $display("FAIL single_loc got=%h exp=%h", rover_location, exp_loc); end
    total++; if (no_target !== exp_nt) begin bad++; $display("FAIL single_nt got=%b exp=%b", no_target, exp_nt); end
    total++; if (sw_busy_at_done !== 1'b1 || sw_done_after !== 1'b0 || sw_busy_after !== 1'b0) begin bad++; $display("FAIL single_done_pulse got=%b%b%b exp=100", sw_busy_at_done, sw_done_after, sw_busy_after); end
  endtask

  task automatic test_median();
    clear_echo();
    echo_len[0][0] = 40; echo_len[0][1] = 28; echo_len[0][2] = 45;
    rand_dly = 1;
    do_sweep(10'h001, 0);
    exp_loc = 12'h019; exp_nt = 0;
    total++; if (sw_tmo || rover_location !== exp_loc) begin bad++; $display("FAIL median_loc got=%h exp=%h", rover_location, exp_loc); end
  endtask

  task automatic test_multi_busy();
    clear_echo();
    for (int s = 0; s < 6; s++) for (int k = 0; k < 3; k++) echo_len[s][k] = (s == 3) ? 28 : 45;
    do_sweep(10'h03F, 1);
    exp_loc = 12'h313; exp_nt = 0;
    total++; if (sw_tmo || rover_location !== exp_loc) begin bad++; $display("FAIL multi_loc got=%h exp=%h", rover_location, exp_loc); end
    total++; if (sw_done_after !== 1'b0 || state !== 4'd0) begin bad++; $display("FAIL multi_idle got=%0d exp=0", state); end
  endtask

  task automatic test_timeout();
    int exp_low;
    logic [NS-1:0] exp_and;
    clear_echo();
    for (int k = 0; k < 3; k++) begin echo_len[4][k] = 101; echo_len[5][k] = 60; end
`ifdef ULTRASOUND_POWER_CYCLE_EN
    exp_low = 3 * PWR; exp_and = 10'h3EF;
`else
    exp_low = 0; exp_and = 10'h3FF;
`endif
    do_sweep(10'h030, 0);
    exp_loc = 12'h523; exp_nt = 0;
    total++; if (sw_tmo || rover_location !== exp_loc) begin bad++; $display("FAIL timeout_loc got=%h exp=%h", rover_location, exp_loc); end
    total++; if (sw_pwr_low != exp_low) begin bad++; $display("FAIL timeout_power_cycles got=%0d exp=%0d", sw_pwr_low, exp_low); end
    total++; if (sw_pwr_and !== exp_and) begin bad++; $display("FAIL timeout_power_bits got=%h exp=%h", sw_pwr_and, exp_and); end
  endtask

  task automatic test_boundary();
    clear_echo();
    echo_len[0][0] = 99; echo_len[0][1] = 100; echo_len[0][2] = 99;
    echo_len[1][0] = 0;  echo_len[1][1] = 1;   echo_len[1][2] = 100;
    do_sweep(10'h003, 0);
    exp_loc = 12'h036; exp_nt = 0;
    total++; if (sw_tmo || rover_location !== exp_loc) begin bad++; $display("FAIL boundary_loc got=%h exp=%h", rover_location, exp_loc); end
  endtask

  task automatic test_mask_zero();
    do_sweep(10'h000, 0);
    exp_nt = 1;
    total++; if (sw_st1 !== 4'd7 || sw_cyc != 1) begin bad++; $display("FAIL mask0_latency got=%0d/%0d exp=7/1", sw_st1, sw_cyc); end
    total++; if (no_target !== exp_nt) begin bad++; $display("FAIL mask0_nt got=%b exp=1", no_target); end
    total++; if (rover_location !== exp_loc) begin bad++; $display("FAIL mask0_loc got=%h exp=%h", rover_location, exp_loc); end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_echo();
    for (int k = 0; k < 3; k++) echo_len[2][k] = 60;
    for (int i = 0; i < NS; i++) trig_cnt[i] = 0;
    @(negedge clock); sensor_mask = 10'h004; calculate = 1'b1;
    @(negedge clock); calculate = 1'b0;
    n = 0;
    while (state !== 4'd3 && n < 300) begin @(negedge clock); n++; end
    total++; if (state !== 4'd3) begin bad++; $display("FAIL midrst_reach_measure got=%0d exp=3", state); end
    repeat (5) @(negedge clock);
    reset = 1'b1;
    #1;
    total++; if (state !== 4'd0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_state got=%0d/%b exp=0/0", state, busy); end
    total++; if (ultrasound_commands !== '0 || ultrasound_power !== '1) begin bad++; $display("FAIL midrst_outputs got=%h/%h exp=000/3ff", ultrasound_commands, ultrasound_power); end
    @(negedge clock); reset = 1'b0;
    n = 0;
    while (resp_busy && n < 300) begin @(negedge clock); n++; end
    total++; if (resp_busy) begin bad++; $display("FAIL midrst_echo_idle got=busy exp=idle"); end
    exp_loc = 12'h000;
    do_sweep(10'h004, 0);
    exp_loc = 12'h223; exp_nt = 0;
    total++; if (sw_tmo || rover_location !== exp_loc || no_target !== exp_nt) begin bad++; $display("FAIL midrst_sweep got=%h/%b exp=%h/%b", rover_location, no_target, exp_loc, exp_nt); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      logic [NS-1:0] m;
      bit vld;
      logic [11:0] loc;
      m = NS'($urandom_range(1, (1 << NS) - 1));
      for (int s = 0; s < NS; s++)
        for (int k = 0; k < 3; k++) begin
          int r;
          r = $urandom_range(0, 9);
          echo_len[s][k] = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(100, 103)) : int'($urandom_range(1, 99));
        end
      model(m, vld, loc);
      do_sweep(m, 0);
      if (vld) exp_loc = loc;
      exp_nt = !vld;
      total++; if (sw_tmo || rover_location !== exp_loc || no_target !== exp_nt) begin bad++; $display("FAIL random%0d mask=%h got=%h/%b exp=%h/%b", it, m, rover_location, no_target, exp_loc, exp_nt); end
    end
  endtask

  initial begin
    reset = 1'b1; calculate = 1'b0; sensor_mask = '0;
    for (int i = 0; i < NS; i++) trig_cnt[i] = 0;
    clear_echo();
    test_reset();
    test_single();
    test_median();
    test_multi_busy();
    test_timeout();
    test_boundary();
    test_mask_zero();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ultrasound_array_ranger.md
# ultrasound_array_ranger

Parametrised successor to the single-configuration ultrasound locator. Sequences triggers across NUM_SENSORS ultrasound channels, times each echo pulse SAMPLES=3 times per sensor, takes the median, adds a fixed sensor-radius offset, and reports the nearest valid sensor as {index, distance}. Sits between the ultrasound connector pins and the rover-tracking logic on the main FPGA.

## Interface
- NUM_SENSORS, 10, channel count (1..16)
- IDX_W, 4, index field width (≥ clog2(NUM_SENSORS))
- DIST_W, 8, distance field width
- CNT_W, 16, echo/timeout counter width
- DIV_SHIFT, 1, distance = echo_cycles >> DIV_SHIFT
- OFFSET, 5, added to median distance, saturating at 2^DIST_W-1
- TRIGGER_CYCLES, 4, trigger pulse length
- GAP_CYCLES, 5, settle time between pings
- TIMEOUT, 100, max cycles in WAIT_RISE or MEASURE
- POWER_OFF_CYCLES, 6, sensor power-off time after timeout
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- calculate  in  1  start pulse; sampled only in IDLE
- sensor_mask  in  NUM_SENSORS  enabled channels; latched on start
- ultrasound_signals  in  NUM_SENSORS  echo inputs
- ultrasound_commands  out  NUM_SENSORS  trigger outputs
- ultrasound_power  out  NUM_SENSORS  sensor power enables
- rover_location  out  IDX_W+DIST_W  {index, distance}; held until next done
- no_target  out  1  no enabled sensor produced a valid median
- done  out  1  one-cycle pulse at end of sweep
- busy  out  1  high in every state except IDLE
- state  out  4  current FSM state encoding

## Operation
- Reset values: commands 0, power all ones, rover_location 0, no_target 0, done 0, busy 0, state IDLE (0).
- States: IDLE(0), TRIGGER(1), WAIT_RISE(2), MEASURE(3), POWER_OFF(4), GAP(5), MEDIAN(6), REPORT(7).
- IDLE: calculate=1 → latch sensor_mask, select lowest enabled index, → TRIGGER. Mask zero → REPORT directly (no_target=1).
- TRIGGER: commands[idx]=1 for TRIGGER_CYCLES cycles → WAIT_RISE.
- WAIT_RISE: echo high → MEASURE with count=1; TIMEOUT cycles without echo → sample invalid.
- MEASURE: count+1 per high cycle; echo low → sample = count>>DIV_SHIFT (saturate to DIST_W), → GAP. count reaching TIMEOUT → sample invalid.
- Invalid sample → POWER_OFF (macro on) or GAP (macro off).
- GAP: GAP_CYCLES idle; then TRIGGER for next sample, or MEDIAN after 3rd.
- MEDIAN (1 cycle): invalid samples treated as all-ones; median of 3; result invalid if ≥2 samples invalid; else add OFFSET saturating. Store per sensor; next enabled index → TRIGGER, none left → REPORT.
- REPORT (1 cycle): minimum valid distance; tie → lowest index. Update rover_location, no_target; done=1; → IDLE. No valid → rover_location unchanged, no_target=1.
- calculate while busy ignored. Echo on a non-selected channel ignored. Reset mid-sweep aborts immediately; power restored at once.

## Timing
- calculate at edge k → state TRIGGER and commands[idx] high from edge k+1.
- Echo of H high cycles → sample H>>DIV_SHIFT, stored on the edge after the falling echo is sampled.
- Per valid ping: TRIGGER_CYCLES + wait + H + GAP_CYCLES cycles.
- done asserted exactly one cycle; busy falls the same edge done falls.
- Outputs registered; no combinational path from inputs to outputs.

## Configuration
- ULTRASOUND_POWER_CYCLE_EN defined: timeout → POWER_OFF, ultrasound_power[idx]=0 for POWER_OFF_CYCLES, then GAP.
- Undefined: POWER_OFF state never entered; power stays all ones; timeout → GAP directly.

## Structure
- Package ultrasound_pkg: state encodings, median3 function with invalid flags, saturating add helper.
- Sub-module ultrasound_echo_timer: rise/fall detection, counter, timeout flag, sample valid strobe; shared across channels via mux on idx.

## Test plan
- Sensor 0 only, echo 40 cycles ×3 → median 20, rover_location {0, 25}, done one cycle.
- Sensor 0 echoes 40/28/45 → samples 20/14/22, median 20 → distance 25.
- Sensors 0–5 enabled, sensor 3 echoes 28 cycles, others 45 → {3, 19} (0x313).
- Sensor 4 never falls (101 cycles) ×3, macro on → power[4] low 6 cycles each time, median invalid, excluded from minimum.
- Mask 0 → done next REPORT cycle, no_target=1, rover_location unchanged.
- Reset asserted in MEASURE → state IDLE, commands 0, power all ones same cycle; next calculate sweeps normally.
